// File: rtl/mio_bus_responder_pkg.sv
// Shared definitions for the MIO bus responder: address regions, peripheral
// base nibbles and responder FSM states.
package mio_bus_responder_pkg;

   typedef enum logic [1:0] {
      REG_RAM  = 2'd0,
      REG_CNT  = 2'd1,
      REG_GPIO = 2'd2,
      REG_NONE = 2'd3
   } region_t;

   localparam logic [3:0] CNT_BASE  = 4'hE;
   localparam logic [3:0] GPIO_BASE = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RAM_WAIT = 2'd1,
      ST_RESP     = 2'd2
   } state_t;

endpackage

// File: rtl/mio_bus_responder_if.sv
// CPU-side MIO request/response bundle; the CPU drives the master modport,
// the responder takes the slave modport.
interface mio_bus_if;
   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        MIO_ready;
   logic        bus_err;

   modport master (
      output CPU_MIO, mem_w, addr, wdata,
      input  rdata, MIO_ready, bus_err
   );

   modport slave (
      input  CPU_MIO, mem_w, addr, wdata,
      output rdata, MIO_ready, bus_err
   );
endinterface

// File: rtl/mio_bus_responder_addr_decode.sv
// Combinational region decode from the top address nibble.
module mio_addr_decode
   import mio_bus_responder_pkg::*;
(
   input  logic [3:0] addr_hi_i,
   output region_t    region_o
);

   // Any nibble with bit 3 clear is RAM; the upper half is mostly unmapped.
   always_comb begin
      region_o = REG_NONE;
      if (!addr_hi_i[3]) begin
         region_o = REG_RAM;
      end else if (addr_hi_i == CNT_BASE) begin
         region_o = REG_CNT;
      end else if (addr_hi_i == GPIO_BASE) begin
         region_o = REG_GPIO;
      end
   end

endmodule

// File: rtl/mio_bus_responder.sv
// Word-access memory/IO responder: accepts one request at a time, serves the
// data RAM through a fixed wait sequence and answers counter/GPIO directly.
module mio_bus_responder
   import mio_bus_responder_pkg::*;
#(
   parameter int RAM_AW  = 10,
   parameter int RAM_LAT = 2,
   parameter int LED_W   = 16,
   parameter int SW_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   mio_bus_if.slave          bus,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   input  logic [SW_W-1:0]   sw_in,
   output logic [LED_W-1:0]  led_out
);

   localparam int WCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   state_t             state_q, state_d;
   logic [WCW-1:0]     wait_q, wait_d;
   logic               mem_w_q, mem_w_d;
   logic               err_q, err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               ram_en_q, ram_en_d;
   logic               ram_we_q, ram_we_d;
   logic [RAM_AW-1:0]  ram_addr_q, ram_addr_d;
   logic [31:0]        ram_din_q, ram_din_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic [31:0]        cnt_q, cnt_d;
   region_t            region;
   logic               unused_addr_bits;

   mio_addr_decode u_decode (
      .addr_hi_i (bus.addr[31:28]),
      .region_o  (region)
   );

   // Byte-lane bits and RAM-aliased upper bits carry no information here.
   assign unused_addr_bits = ^bus.addr;

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      mem_w_d    = mem_w_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      ram_en_d   = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      led_d      = led_q;
      cnt_d      = cnt_q + 32'd1;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.CPU_MIO) begin
               mem_w_d = bus.mem_w;
               err_d   = 1'b0;
               rdata_d = '0;
               state_d = ST_RESP;
               unique case (region)
                  REG_RAM: begin
                     state_d    = ST_RAM_WAIT;
                     wait_d     = WCW'(RAM_LAT - 1);
                     ram_en_d   = 1'b1;
                     ram_we_d   = bus.mem_w;
                     ram_addr_d = bus.addr[RAM_AW+1:2];
                     ram_din_d  = bus.wdata;
                  end
                  REG_CNT: begin
                     // A load replaces this cycle's increment.
                     if (bus.mem_w) cnt_d = bus.wdata;
                     else           rdata_d = cnt_q;
                  end
                  REG_GPIO: begin
                     if (bus.mem_w) led_d = bus.wdata[LED_W-1:0];
                     else           rdata_d = 32'(sw_in);
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
            end
         end
         ST_RAM_WAIT: begin
            if (wait_q == '0) begin
               state_d = ST_RESP;
               if (!mem_w_q) rdata_d = ram_dout;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         mem_w_q    <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         led_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         mem_w_q    <= mem_w_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         ram_en_q   <= ram_en_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         led_q      <= led_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.MIO_ready = (state_q == ST_RESP);
   assign bus.bus_err   = (state_q == ST_RESP) && err_q;
   assign ram_en        = ram_en_q;
   assign ram_we        = ram_we_q;
   assign ram_addr      = ram_addr_q;
   assign ram_din       = ram_din_q;
   assign led_out       = led_q;

endmodule
